// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_LOCK = 1'b1
   } arb_state_t;

   // Index width that never collapses to zero bits.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_prio_enc.sv
// Rotating-priority first-one search: first set req bit at ptr, ptr+1, ... modulo N.
module rr_prio_enc
   import fifo_arb_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]                req,
   input  logic [clog2_min1(N)-1:0]    ptr,
   output logic                        any,
   output logic [clog2_min1(N)-1:0]    idx
);

   localparam int IW = clog2_min1(N);

   always_comb begin
      any = 1'b0;
      idx = '0;
      for (int unsigned k = 0; k < N; k++) begin
         if (!any && req[(32'(ptr) + k) % N]) begin
            any = 1'b1;
            idx = IW'((32'(ptr) + k) % N);
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing one fifo_ctrl write port between NUM_REQ producers,
// with burst locking and a MAX_BURST forced release.
module fifo_wr_arb
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int DAT_WID   = 32,
   parameter int MAX_BURST = 16
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_REQ-1:0]             req,
   input  logic [NUM_REQ-1:0]             last,
   input  logic [NUM_REQ*DAT_WID-1:0]     din,
   input  logic                           full,
   output logic [NUM_REQ-1:0]             gnt,
   output logic                           wen,
   output logic [DAT_WID-1:0]             wr_data,
   output logic [clog2_min1(NUM_REQ)-1:0] owner,
   output logic                           locked,
   output logic                           burst_err
);

   localparam int IDX_WID  = clog2_min1(NUM_REQ);
   localparam int BCNT_WID = $clog2(MAX_BURST + 1);

   arb_state_t           r_state;
   logic [IDX_WID-1:0]   r_rr_ptr;
   logic [IDX_WID-1:0]   r_owner;
   logic [BCNT_WID-1:0]  r_beat_cnt;
   logic                 r_burst_err;

   logic                 w_any;
   logic [IDX_WID-1:0]   w_win;
   logic [IDX_WID-1:0]   w_sel;
   logic                 w_sel_vld;
   logic [NUM_REQ-1:0]   w_gnt;
   logic                 w_xfer;
   logic                 w_last;
   logic [BCNT_WID-1:0]  w_cnt_nxt;
   logic                 w_cap;

   function automatic logic [IDX_WID-1:0] next_idx(input logic [IDX_WID-1:0] i);
      return (32'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
   endfunction

   rr_prio_enc #(
      .N (NUM_REQ)
   ) u_enc (
      .req (req),
      .ptr (r_rr_ptr),
      .any (w_any),
      .idx (w_win)
   );

   // beat_cnt is 0 in IDLE, so the cap test also covers a first beat with MAX_BURST=1.
   always_comb begin
      w_sel     = (r_state == ARB_LOCK) ? r_owner : w_win;
      w_sel_vld = rst_n & ~full & ((r_state == ARB_LOCK) | w_any);
      w_gnt     = '0;
      if (w_sel_vld)
         w_gnt[w_sel] = 1'b1;
      w_xfer    = |(req & w_gnt);
      w_last    = last[w_sel];
      w_cnt_nxt = r_beat_cnt + 1'b1;
      w_cap     = (w_cnt_nxt == BCNT_WID'(MAX_BURST));
      wr_data   = w_sel_vld ? din[w_sel*DAT_WID +: DAT_WID] : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ARB_IDLE;
         r_rr_ptr    <= '0;
         r_owner     <= '0;
         r_beat_cnt  <= '0;
         r_burst_err <= 1'b0;
      end else begin
         r_burst_err <= 1'b0;
         if (w_xfer) begin
            r_owner <= w_sel;
            if (w_last || w_cap) begin
               r_state     <= ARB_IDLE;
               r_beat_cnt  <= '0;
               r_rr_ptr    <= next_idx(w_sel);
               r_burst_err <= ~w_last;
            end else begin
               r_state    <= ARB_LOCK;
               r_beat_cnt <= w_cnt_nxt;
            end
         end
      end
   end

   assign gnt       = w_gnt;
   assign wen       = w_xfer;
   assign owner     = r_owner;
   assign locked    = (r_state == ARB_LOCK);
   assign burst_err = r_burst_err;

endmodule
